// File: rtl/prog_loader.sv
// prog_loader: assembles a byte-stream program image into instruction-memory words and holds the CPU until the image verifies
module prog_loader #(
  parameter int                ADDR_W    = 32,
  parameter int                MAX_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_byte_i,
  output logic              in_ready_o,
  output logic              mem_w_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              cpu_hold_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, idx_q, idx_d, hdr;
  logic [1:0]        bcnt_q, bcnt_d;
  logic [7:0]        chk_q, chk_d;
  logic [23:0]       sh_q, sh_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic              hold_q, xfer;
  assign in_ready_o = state_q inside {CNT_HI, CNT_LO, DATA, CHECK};
  assign xfer       = in_valid_i & in_ready_o;
  assign hdr        = {cnt_q[15:8], in_byte_i};
  assign mem_w_o    = state_q == WRITE;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;
  assign cpu_hold_o = hold_q;
  assign done_o     = state_q == DONE;
  assign err_o      = state_q == ERROR;
  // next-state: header parse, word assembly, running checksum and write address
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    bcnt_d  = bcnt_q;
    chk_d   = chk_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE, DONE, ERROR: if (start_i) begin
        state_d = CNT_HI;
        idx_d   = '0;
        bcnt_d  = '0;
        chk_d   = '0;
      end
      CNT_HI: if (xfer) begin
        cnt_d[15:8] = in_byte_i;
        state_d     = CNT_LO;
      end
      CNT_LO: if (xfer) begin
        cnt_d[7:0] = in_byte_i;
        state_d    = int'(hdr) > MAX_WORDS ? ERROR : hdr == 16'd0 ? CHECK : DATA;
      end
      DATA: if (xfer) begin
        sh_d   = {sh_q[15:0], in_byte_i};
        chk_d  = chk_q ^ in_byte_i;
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          state_d = WRITE;
          data_d  = {sh_q, in_byte_i};
          addr_d  = BASE_ADDR + ADDR_W'(idx_q);
        end
      end
      WRITE: begin
        idx_d   = idx_q + 16'd1;
        state_d = idx_q + 16'd1 == cnt_q ? CHECK : DATA;
      end
      CHECK: if (xfer) state_d = in_byte_i == chk_q ? DONE : ERROR;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; cpu_hold is registered from the next state so it never glitches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      bcnt_q  <= '0;
      chk_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
      chk_q   <= chk_d;
      sh_q    <= sh_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      hold_q  <= state_d != DONE;
    end
  end
endmodule
